// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment lookup for the seven-segment driver
// Contents: SEG_BLANK (all segments off, active-low), SEG_LUT (16-entry active-low
// a..g table with dp off), hex_to_seg(nibble, dp) -> 8-bit active-low segment code.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index = hex value; bit0..6 = a..g, bit7 = dp (1 = off).
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
    logic [7:0] code;
    code    = SEG_LUT[nibble];
    code[7] = ~dp;
    return code;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - combinational nibble + decimal point to active-low segment code
// Ports: nibble (4) hex digit in, dp (1) decimal point lit, seg (8) active-low a..g,dp out.
module seg7_encoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = hex_to_seg(nibble, dp);

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - time-multiplexed hex driver for a seven-segment bank
// Ports: clk, RESET (sync, active-high); NUMBER (4*DIGITS) hex nibbles, DP (DIGITS)
// decimal points, AN_MASK (DIGITS) force-dark, BLANK_LZ leading-zero blank, BRIGHT
// (BRIGHT_W) PWM duty; AN (DIGITS) digit enables, SEG (8) segments, FRAME_TICK pulse
// after the scan wraps. AN/SEG/FRAME_TICK are registered.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int BRIGHT_W    = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   NUMBER,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     AN_MASK,
  input  logic                  BLANK_LZ,
  input  logic [BRIGHT_W-1:0]   BRIGHT,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEG,
  output logic                  FRAME_TICK
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(REFRESH_DIV - 1);
  // Everything is built active-low internally; active-high builds flip at the output register.
  localparam bit INV = !ACTIVE_LOW;

  logic [PRESC_W-1:0]  presc;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [4*DIGITS-1:0] shadow_num;
  logic [DIGITS-1:0]   shadow_dp;

  logic                presc_term;
  logic                frame_edge;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_mask;
  logic                cur_blank;
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   an_sel_low;
  logic                lit;
  logic                an_on;
  logic [7:0]          enc_seg;
  logic [DIGITS-1:0]   an_next_low;
  logic [7:0]          seg_next_low;

  assign presc_term = (presc == LAST_PRESC);
  assign frame_edge = presc_term && (idx == LAST_IDX);

  // upper_zero[i] = shadow nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run && (shadow_num[4*i +: 4] == 4'h0);
      upper_zero[i] = run;
    end
  end

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_mask   = 1'b0;
    cur_blank  = 1'b0;
    an_sel_low = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = shadow_num[4*i +: 4];
        cur_dp        = shadow_dp[i];
        cur_mask      = AN_MASK[i];
        cur_blank     = BLANK_LZ && (i != 0) && upper_zero[i];
        an_sel_low[i] = 1'b0;
      end
    end
  end

  seg7_encoder u_encoder (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (enc_seg)
  );

  assign lit          = (BRIGHT == '1) || (pwm_cnt < BRIGHT);
  assign an_on        = lit && !cur_blank && !cur_mask;
  // Segments follow the anode so a dark slot never ghosts the previous digit.
  assign an_next_low  = an_on ? an_sel_low : '1;
  assign seg_next_low = an_on ? enc_seg : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (RESET) begin
      presc      <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      FRAME_TICK <= 1'b0;
      shadow_num <= NUMBER;
      shadow_dp  <= DP;
      AN         <= {DIGITS{1'b1}} ^ {DIGITS{INV}};
      SEG        <= SEG_BLANK ^ {8{INV}};
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      FRAME_TICK <= frame_edge;
      AN         <= an_next_low ^ {DIGITS{INV}};
      SEG        <= seg_next_low ^ {8{INV}};
      if (presc_term) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      // New display data is only taken at the frame boundary, so a frame never mixes old and new.
      if (frame_edge) begin
        shadow_num <= NUMBER;
        shadow_dp  <= DP;
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - directed self-checking bench for seg7_mux_driver
module tb_seg7_mux_driver;

  logic        clk;
  logic        reset;
  logic [15:0] number;
  logic [3:0]  dp;
  logic [3:0]  an_mask;
  logic        blank_lz;
  logic [1:0]  bright;
  logic [3:0]  an_lo, an_hi;
  logic [7:0]  seg_lo, seg_hi;
  logic        tick_lo, tick_hi;

  int tests = 0;
  int fails = 0;

  seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .RESET(reset), .NUMBER(number), .DP(dp), .AN_MASK(an_mask),
    .BLANK_LZ(blank_lz), .BRIGHT(bright), .AN(an_lo), .SEG(seg_lo), .FRAME_TICK(tick_lo)
  );

  seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .RESET(reset), .NUMBER(number), .DP(dp), .AN_MASK(an_mask),
    .BLANK_LZ(blank_lz), .BRIGHT(bright), .AN(an_hi), .SEG(seg_hi), .FRAME_TICK(tick_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag, input int k);
    chk({tag, ".an"}, k, {4'h0, an_lo}, 8'h0F);
    chk({tag, ".seg"}, k, seg_lo, 8'hFF);
    chk({tag, ".tick"}, k, {7'h0, tick_lo}, 8'h00);
    chk({tag, ".an_hi"}, k, {4'h0, an_hi}, 8'h00);
    chk({tag, ".seg_hi"}, k, seg_hi, 8'h00);
  endtask

  // One 16-cycle frame (4 slots x 4 cycles). segs = {d3,d2,d1,d0} active-low codes,
  // act = digits not blanked/masked. Optionally changes NUMBER after edge chg_at.
  task automatic run_frame(input string tag, input logic [31:0] segs, input logic [3:0] act,
                           input int chg_at, input logic [15:0] chg_val, input bit do_check);
    for (int k = 0; k < 16; k++) begin
      int         s;
      bit         on;
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      step();
      if (k == chg_at) number = chg_val;
      if (do_check) begin
        s       = k / 4;
        on      = act[s] && ((bright == 2'b11) || ((k % 4) < int'(bright)));
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
        if (on) begin
          exp_an[s] = 1'b0;
          exp_seg   = segs[8*s +: 8];
        end
        chk({tag, ".an"}, k, {4'h0, an_lo}, {4'h0, exp_an});
        chk({tag, ".seg"}, k, seg_lo, exp_seg);
        chk({tag, ".tick"}, k, {7'h0, tick_lo}, {7'h0, (k == 15)});
        chk({tag, ".an_hi"}, k, {4'h0, an_hi}, {4'h0, ~exp_an});
        chk({tag, ".seg_hi"}, k, seg_hi, ~exp_seg);
        chk({tag, ".tick_hi"}, k, {7'h0, tick_hi}, {7'h0, (k == 15)});
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    number   = 16'h1234;
    dp       = 4'h0;
    an_mask  = 4'h0;
    blank_lz = 1'b0;
    bright   = 2'd3;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_state("reset", i);
    end
    reset = 1'b0;

    run_frame("scan1", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111, -1, 16'h0, 1'b1);
    run_frame("scan2", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111, -1, 16'h0, 1'b1);

    number   = 16'h0070;
    blank_lz = 1'b1;
    run_frame("skip", 32'h0, 4'h0, -1, 16'h0, 1'b0);
    run_frame("blank_lz1", {8'hFF, 8'hFF, 8'hF8, 8'hC0}, 4'b0011, -1, 16'h0, 1'b1);
    blank_lz = 1'b0;
    run_frame("blank_lz0", {8'hC0, 8'hC0, 8'hF8, 8'hC0}, 4'b1111, -1, 16'h0, 1'b1);

    number = 16'h0000;
    dp     = 4'b0100;
    run_frame("skip", 32'h0, 4'h0, -1, 16'h0, 1'b0);
    run_frame("dp", {8'hC0, 8'h40, 8'hC0, 8'hC0}, 4'b1111, -1, 16'h0, 1'b1);
    an_mask = 4'b0001;
    run_frame("mask", {8'hC0, 8'h40, 8'hC0, 8'hC0}, 4'b1110, -1, 16'h0, 1'b1);

    an_mask = 4'h0;
    dp      = 4'h0;
    number  = 16'h1111;
    run_frame("skip", 32'h0, 4'h0, -1, 16'h0, 1'b0);
    run_frame("tear_old", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'b1111, 5, 16'h2222, 1'b1);
    run_frame("tear_new", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111, -1, 16'h0, 1'b1);

    bright = 2'd1;
    run_frame("bright1", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111, -1, 16'h0, 1'b1);
    bright = 2'd0;
    run_frame("bright0", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111, -1, 16'h0, 1'b1);

    bright = 2'd3;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    chk_reset_state("mid_reset", 0);
    reset = 1'b0;
    run_frame("after_reset", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111, -1, 16'h0, 1'b1);

    number = 16'h0008;
    run_frame("skip", 32'h0, 4'h0, -1, 16'h0, 1'b0);
    run_frame("polarity", {8'hC0, 8'hC0, 8'hC0, 8'h80}, 4'b1111, -1, 16'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
Parametrised, time-multiplexed hex driver for common-anode or common-cathode seven-segment banks with DIGITS digits. It adds several features to the basic 8-digit scanner:
- programmable refresh prescaler
- per-digit decimal points
- leading-zero blanking
- PWM brightness
- tear-free frame-latched display data
It sits between the register/debug logic that produces NUMBER and the board display pins.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16)
REFRESH_DIV, 1000, clk cycles each digit is selected (>=2)
BRIGHT_W, 4, width of brightness control
ACTIVE_LOW, 1, 1 = AN and SEG driven active-low; 0 = both inverted to active-high

Ports:
clk  in  1  clock
RESET  in  1  synchronous, active-high reset
NUMBER  in  4*DIGITS  hex nibbles; nibble i = NUMBER[4i+3:4i] shown on digit i
DP  in  DIGITS  decimal point enable per digit (1 = lit)
AN_MASK  in  DIGITS  1 forces digit i dark
BLANK_LZ  in  1  1 = blank leading zero digits
BRIGHT  in  BRIGHT_W  brightness; 0 = dark, all-ones = full on
AN  out  DIGITS  digit enables, registered
SEG  out  8  segments: bit0..6 = a..g, bit7 = dp; registered
FRAME_TICK  out  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset (RESET=1 at clk edge) clears prescaler, digit index, PWM counter and FRAME_TICK.
  - AN = all inactive; SEG = all inactive (8'hFF when ACTIVE_LOW=1, 8'h00 when 0).
  - Shadow registers load NUMBER/DP on every reset cycle.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At its terminal count the index advances by 1 modulo DIGITS; index width is max(1, clog2(DIGITS)).
- Frame latch: on the edge where prescaler is terminal and index = DIGITS-1:
  - shadow NUMBER/DP load from the inputs;
  - FRAME_TICK is 1 for the following cycle.
  - Inputs changed mid-frame have no visible effect until the next frame.
- AN_MASK, BLANK_LZ and BRIGHT are not shadowed; they take effect with the normal output latency.
- Output latency: AN/SEG at cycle t+1 reflect index, PWM state and shadow values at cycle t.
- Active-low segment encoding (ACTIVE_LOW=0 gives the bitwise inverse), with dp off:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
  - Shadow DP[index]=1 sets bit7 active (cleared in active-low).
- Leading-zero blank: digit i (i>0) is blank when BLANK_LZ=1 and shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- PWM: a BRIGHT_W-bit counter free-runs (+1 per clk, wraps).
  - Digit is lit iff BRIGHT = all-ones, or pwm_cnt < BRIGHT.
  - BRIGHT=0: AN stays all inactive.
- Selected AN bit is active iff lit, not blanked and AN_MASK[index]=0. All other AN bits are inactive.
- When the selected AN bit is inactive, SEG is driven all-inactive (no ghosting).
- Exactly zero or one AN bit is active in any cycle.
- DIGITS=1: index stays 0; FRAME_TICK pulses every REFRESH_DIV cycles.
- Reset asserted mid-scan: outputs go inactive the next edge; scanning restarts at digit 0, prescaler 0.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant;
  - 16-entry active-low segment table;
  - function hex_to_seg(nibble, dp) returning the 8-bit active-low code.
- One sub-module, seg7_encoder: combinational nibble+dp -> SEG code, polarity applied in the top level.
- The prescaler, scan, PWM, blanking and shadow logic stay in seg7_mux_driver.

Test Plan:
Bench configuration unless stated: DIGITS=4, REFRESH_DIV=4, BRIGHT_W=2, ACTIVE_LOW=1.
1. Reset: RESET high 3 cycles, then low -> during reset AN=4'hF, SEG=8'hFF, FRAME_TICK=0; first lit cycle after release shows digit 0.
2. Scan: NUMBER=16'h1234, BRIGHT=3, masks 0 -> slots of 4 cycles: AN=1110/SEG=99, AN=1101/SEG=B0, AN=1011/SEG=A4, AN=0111/SEG=F9; FRAME_TICK every 16 cycles.
3. Blanking:
   - NUMBER=16'h0070, BLANK_LZ=1 -> digits 3,2 keep AN bit 1 and SEG=FF; digit1 SEG=F8; digit0 SEG=C0.
   - Same NUMBER with BLANK_LZ=0 -> digit3 SEG=C0.
4. DP and mask:
   - NUMBER=0, DP=4'b0100 -> slot 2 SEG=8'h40.
   - AN_MASK=4'b0001 -> AN[0] never 0.
5. Tear-free latch: change NUMBER from 16'h1111 to 16'h2222 during digit 1 -> digits 2,3 still show F9; A4 appears only after FRAME_TICK.
6. Brightness and polarity:
   - BRIGHT=1 -> exactly 1 of 4 cycles active per slot; BRIGHT=0 -> AN=4'hF throughout.
   - ACTIVE_LOW=0 build, NUMBER=16'h0008 -> digit0 AN=0001, SEG=8'h7F.
